ysyx_220053_ifu: RTL
====================

Name: ysyx_220053_ifu

Overview:
Instruction fetch unit sitting directly upstream of the decoder/controller. It holds the PC and issues one-at-a-time word fetches to instruction memory over a valid/ready request + valid response bus. Returned words go into a 2-entry {pc, instr} buffer that feeds the decoder through a valid/ready handshake. It accepts PC redirects (branch/jump) and a halt (ebreak) from downstream.

Parameters:
PC_W, 64, PC/address width
RESET_PC, 64'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  PC_W  fetch address, word aligned
imem_resp_valid  in  1  response data valid (no ready; IFU always accepts)
imem_resp_data  in  32  fetched instruction word
instr_valid  out  1  buffer head valid toward decoder
instr_ready  in  1  decoder consumes head this cycle
instr_o  out  32  head instruction
pc_o  out  PC_W  head PC
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  PC_W  target PC; bits [1:0] ignored (forced 0)
halt_i  in  1  level; blocks issue of new requests

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, state=IDLE, buffer empty, drop flag=0; imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_o=0, pc_o=0. Reset mid-operation discards buffer and any outstanding response; a response arriving in the cycle after reset deassertion while IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when !halt_i and (buffer count + outstanding) < 2. No request issued in reset-release cycle's own edge; first imem_req_valid rises 1 cycle after rst deasserts.
  - REQ: imem_req_valid=1, imem_req_addr=pc_q. On valid&&ready: fifo_pc_pending=pc_q, pc_q=pc_q+4 (modulo 2^PC_W, wrap allowed), -> WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid: if drop=0 push {pending pc, data}; if drop=1 discard, clear drop. -> REQ if issue condition still holds else IDLE.
- Max one outstanding request. Memory must sample addr only on valid&&ready; addr may change while unaccepted only due to redirect.
- Fetch-to-decoder latency: instr_valid rises the cycle after imem_resp_valid (buffer registered); with zero-latency ready memory, sustained throughput 1 instr / 2 cycles.
- Buffer: 2-entry FIFO, head on instr_o/pc_o. Pop on instr_valid&&instr_ready. Push and pop same cycle allowed at any occupancy (count unchanged when full only because issue rule guarantees no push into full without pop).
- Redirect (redirect_valid=1): next cycle buffer empty, instr_valid=0, pc_q={redirect_pc[PC_W-1:2],2'b00}.
  - In IDLE/REQ: state -> REQ (if !halt_i) with new addr; an unaccepted request is abandoned, even if imem_req_ready is high that same cycle (redirect wins; that handshake is not counted).
  - In WAIT: drop=1, stay WAIT; the pending response is discarded.
  - Redirect coincident with imem_resp_valid in WAIT: response discarded, drop not set, -> REQ.
  - Redirect coincident with decoder pop: flush wins; popped entry is still considered consumed by decoder.
- halt_i=1: no REQ entry; a request already in REQ completes handshake; outstanding response still buffered; buffered entries still delivered. Redirect while halted updates pc_q but issues nothing until halt_i=0.
- instr_o/pc_o hold last head value when instr_valid=0 (no reset to zero except by rst).

Test Plan:
- Reset release, memory always ready, 1-cycle response, instr_ready=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; pc_o follows same sequence, instr_o matches returned data, one instr every 2 cycles.
- instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid stays 0 after second response; release -> entries popped in order, fetch resumes at 0x8000_0008.
- Request accepted at 0x8000_0010, redirect to 0x8000_0103 while WAIT -> response dropped, next request addr 0x8000_0100, first delivered pc_o=0x8000_0100.
- Redirect same cycle as imem_resp_valid and as a decoder pop -> no instr_valid next cycle, next request at redirect target, no stale entry ever appears.
- halt_i=1 while REQ with imem_req_ready=0 for 3 cycles then 1 -> that single request completes and its instr delivered; no further imem_req_valid until halt_i=0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request addr wraps to 0; assert rst mid-WAIT -> all outputs at reset values immediately, late response ignored.

Source files
------------

// File: rtl/ysyx_220053_ifu_if.sv
// rtl/ysyx_220053_ifu_if.sv - signal bundle between the fetch unit, instruction memory and decoder
//
// Purpose: groups every non-clock/reset signal of ysyx_220053_ifu.
// Ports (direction seen from the master = fetch unit):
//   imem_req_valid  out       fetch request valid
//   imem_req_ready  in        memory accepts the request this cycle
//   imem_req_addr   out PC_W  word-aligned fetch address
//   imem_resp_valid in        returned word valid (always accepted)
//   imem_resp_data  in  32    returned instruction word
//   instr_valid     out       buffer head valid toward the decoder
//   instr_ready     in        decoder consumes the head this cycle
//   instr_o         out 32    head instruction
//   pc_o            out PC_W  head PC
//   redirect_valid  in        one-cycle restart pulse
//   redirect_pc     in  PC_W  restart target (low two bits ignored)
//   halt_i          in        level; blocks new requests
interface ysyx_220053_ifu_if #(
  parameter int PC_W = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_o;
  logic [PC_W-1:0] pc_o;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt_i;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_o, pc_o,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc, halt_i
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_o, pc_o,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc, halt_i
  );
endinterface

// File: rtl/ysyx_220053_ifu.sv
// rtl/ysyx_220053_ifu.sv - instruction fetch unit with 2-entry {pc, instr} buffer
//
// Purpose: holds the PC, issues one word fetch at a time and queues returned
// words for the decoder; accepts redirects and a halt level from downstream.
// Ports:
//   clk  in   clock, all state updates on the rising edge
//   rst  in   asynchronous active-high reset
//   bus  ysyx_220053_ifu_if.master: imem request/response, decoder handoff,
//        redirect and halt (see the interface file for the signal list)
module ysyx_220053_ifu #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_220053_ifu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            drop_q, drop_d;
  logic [1:0]      count_q, count_d;

  logic [PC_W-1:0] head_pc_q, tail_pc_q;
  logic [31:0]     head_ins_q, tail_ins_q;

  logic            req_fire, resp_fire, resp_keep, push, pop;
  logic [1:0]      count_after;
  logic [PC_W-1:0] redirect_tgt;

  assign req_fire     = (state_q == REQ) && bus.imem_req_ready;
  assign resp_fire    = (state_q == WAIT) && bus.imem_resp_valid;
  assign pop          = (count_q != 2'd0) && bus.instr_ready;
  // A response is worth keeping unless an earlier redirect marked it stale.
  assign resp_keep    = resp_fire && !drop_q;
  // A redirect in the same cycle also discards a fresh response.
  assign push         = resp_keep && !bus.redirect_valid;
  // Occupancy once this cycle's response and pop have landed; the decision to
  // issue again from WAIT uses it so a full buffer never gets a third request.
  assign count_after  = count_q + {1'b0, resp_keep} - {1'b0, pop};
  assign redirect_tgt = bus.redirect_pc & ~PC_W'(3);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (!bus.halt_i && (count_q < 2'd2)) state_d = REQ;
      end
      REQ: begin
        // Halt does not abandon a request already on the bus.
        if (req_fire) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + PC_W'(4);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (resp_fire) begin
          drop_d  = 1'b0;
          state_d = (!bus.halt_i && (count_after < 2'd2)) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything: flush the buffer, restart the PC, and
    // abandon any unaccepted request even if the memory is ready this cycle.
    if (bus.redirect_valid) begin
      pc_d      = redirect_tgt;
      pend_pc_d = pend_pc_q;
      count_d   = 2'd0;
      if ((state_q == WAIT) && !bus.imem_resp_valid) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = bus.halt_i ? IDLE : REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      drop_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
    end
  end

  // Shift-style buffer: the head register is only rewritten by a push or a
  // shift, so instr_o/pc_o keep the last delivered entry while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_pc_q  <= '0;
      head_ins_q <= '0;
      tail_pc_q  <= '0;
      tail_ins_q <= '0;
    end else if (!bus.redirect_valid) begin
      if (pop && (count_q == 2'd2)) begin
        head_pc_q  <= tail_pc_q;
        head_ins_q <= tail_ins_q;
      end
      if (push) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          head_pc_q  <= pend_pc_q;
          head_ins_q <= bus.imem_resp_data;
        end else begin
          tail_pc_q  <= pend_pc_q;
          tail_ins_q <= bus.imem_resp_data;
        end
      end
    end
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = (count_q != 2'd0);
  assign bus.instr_o        = head_ins_q;
  assign bus.pc_o           = head_pc_q;

endmodule
